// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the round-robin bus scheduler.
// The statistics counters exist only when BUS_SCHED_STATS_EN is defined.
package bus_sched_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    POP,
    PUSH
  } state_e;

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Device-side bus bundle: FIFO heads in, pop/push strobes and data out.
interface bus_rr_scheduler_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);

  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              push;
  logic [drvrs-1:0][pckg_sz-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after the last grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] gnt,
  output logic          vld
);

  int  idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        gnt   = GW'(idx);
        found = 1'b1;
      end
    end
    vld = found;
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet switch: grant, pop, route by dest ID, push.
// Define BUS_SCHED_STATS_EN to build the delivered/dropped counters.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] bcast_id = BCAST_ID_DEF
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_scheduler_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_e             state_q, state_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [GW-1:0]      last_q, last_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0]   mask_q, mask_d;
  logic [drvrs-1:0]   mask_calc;
  logic [ID_W-1:0]    id;
  logic [GW-1:0]      arb_gnt;
  logic               arb_vld;

  rr_arbiter #(
    .N  (drvrs),
    .GW (GW)
  ) u_arb (
    .req  (bus.pndng),
    .last (last_q),
    .gnt  (arb_gnt),
    .vld  (arb_vld)
  );

  assign id = pkt_q[pckg_sz-1 -: ID_W];

  // Self-addressed and unknown IDs produce an empty mask (a drop).
  always_comb begin
    mask_calc = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (id == bcast_id)
        mask_calc[i] = (gnt_q != GW'(i));
      else
        mask_calc[i] = (id == ID_W'(i)) && (gnt_q != GW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pkt_d   = bus.D_pop[gnt_q];
        state_d = POP;
      end
      POP: begin
        mask_d  = mask_calc;
        state_d = PUSH;
      end
      PUSH: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(drvrs - 1);
      pkt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    bus.pop    = '0;
    bus.push   = '0;
    bus.D_push = '0;
    for (int i = 0; i < drvrs; i++) begin
      bus.pop[i]  = (state_q == GRANT) && (gnt_q == GW'(i));
      bus.push[i] = (state_q == PUSH) && mask_q[i];
      if (bus.push[i])
        bus.D_push[i] = pkt_q;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef BUS_SCHED_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == PUSH) begin
      if (|mask_q) begin
        if (pkt_cnt_q != '1)
          pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else begin
        if (drop_cnt_q != '1)
          drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: device FIFO model, RR and routing model.
module tb_bus_rr_scheduler;

  localparam int N = 4;

  typedef struct {
    int          due;
    logic [N-1:0] mask;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  bus_rr_scheduler_if #(.drvrs(N), .pckg_sz(16)) bus ();

  bus_rr_scheduler #(
    .drvrs   (N),
    .pckg_sz (16),
    .bcast_id(8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .pkt_cnt (pkt_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dq [N][$];
  exp_t sb [$];
  int   grant_log [$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_pop_at = -1;
  int   free_at = 0;
  int   pend_pop = -1;
  int   last_g = N - 1;
  int   last_pop = -10;
  int   m_pkt = 0;
  int   m_drop = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] req, int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N])
        return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] route(logic [15:0] p, int g);
    logic [N-1:0] m;
    int id;
    m  = '0;
    id = int'(p[15:8]);
    if (id == 255) begin
      m    = '1;
      m[g] = 1'b0;
    end else if (id < N && id != g) begin
      m[id] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] exp_cnt(int v);
`ifdef BUS_SCHED_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic load(int dev, logic [15:0] p);
    dq[dev].push_back(p);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.pndng[i] = (dq[i].size() != 0);
      bus.D_pop[i] = (dq[i].size() != 0) ? dq[i][0] : 16'h0;
    end
    if (!reset && exp_pop_at < 0 && cyc >= free_at && bus.pndng != '0)
      exp_pop_at = cyc + 1;
  endtask

  task automatic step();
    int   g;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (pend_pop >= 0) begin
      if (dq[pend_pop].size() != 0)
        void'(dq[pend_pop].pop_front());
      pend_pop = -1;
    end
    if (cyc == exp_pop_at) begin
      g = rr_pick(bus.pndng, last_g);
      chk("pop_grant", 32'(bus.pop), 32'(1 << g));
      grant_log.push_back(g);
      pend_pop = g;
      last_g   = g;
      last_pop = cyc;
      free_at  = cyc + 3;
      exp_pop_at = -1;
      e.due  = cyc + 2;
      e.data = bus.D_pop[g];
      e.mask = route(e.data, g);
      sb.push_back(e);
    end else begin
      chk("pop_idle", 32'(bus.pop), 32'h0);
    end
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("push_mask", 32'(bus.push), 32'(e.mask));
      for (int i = 0; i < N; i++)
        chk($sformatf("d_push%0d", i), 32'(bus.D_push[i]),
            e.mask[i] ? 32'(e.data) : 32'h0);
      if (e.mask != '0) m_pkt++;
      else m_drop++;
    end else begin
      chk("push_idle", 32'(bus.push), 32'h0);
      chk("d_push_idle", 32'(bus.D_push != '0), 32'h0);
    end
    chk("busy", 32'(busy), 32'(cyc >= last_pop && cyc <= last_pop + 2));
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      drive();
      step();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dq[0].size() + dq[1].size() + dq[2].size() + dq[3].size()
            + sb.size() != 0 || exp_pop_at >= 0 || pend_pop >= 0) && n < 200) begin
      cycles(1);
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'h0);
    cycles(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pop", 32'(bus.pop), 32'h0);
    chk("rst_push", 32'(bus.push), 32'h0);
    chk("rst_dpush", 32'(bus.D_push != '0), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    sb.delete();
    exp_pop_at = -1;
    pend_pop   = -1;
    free_at    = 0;
    last_g     = N - 1;
    last_pop   = -10;
    m_pkt      = 0;
    m_drop     = 0;
    cycles(2);
    reset = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.pndng = '0;
    bus.D_pop = '0;
    do_reset();

    // Three devices pending together, then device 0 refilled.
    load(0, 16'h0100);
    load(1, 16'h0300);
    load(3, 16'h0200);
    drain();
    load(0, 16'h0300);
    drain();
    chk("rr_n", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("rr_0", 32'(grant_log[0]), 32'd0);
      chk("rr_1", 32'(grant_log[1]), 32'd1);
      chk("rr_2", 32'(grant_log[2]), 32'd3);
      chk("rr_3", 32'(grant_log[3]), 32'd0);
    end
    chk("rr_pkt_cnt", 32'(pkt_cnt), exp_cnt(m_pkt));

    // Unicast from device 1 to device 2.
    do_reset();
    load(1, 16'h0202);
    cycles(1);
    chk("uc_pop_cycle", 32'(grant_log.size()), 32'd1);
    drain();
    chk("uc_pkt_cnt", 32'(pkt_cnt), exp_cnt(1));
    chk("uc_model_pkt", 32'(m_pkt), 32'd1);

    // Broadcast from device 2.
    do_reset();
    load(2, 16'hFF55);
    drain();
    chk("bc_pkt_cnt", 32'(pkt_cnt), exp_cnt(1));
    chk("bc_drop_cnt", 32'(drop_cnt), exp_cnt(0));

    // Self-addressed and out-of-range IDs are dropped.
    do_reset();
    load(0, 16'h0007);
    load(0, 16'h0907);
    drain();
    chk("drop_cnt", 32'(drop_cnt), exp_cnt(2));
    chk("drop_pkt_cnt", 32'(pkt_cnt), exp_cnt(0));
    chk("drop_model", 32'(m_drop), 32'd2);

    // Reset while the packet sits in POP.
    do_reset();
    load(1, 16'h0305);
    cycles(1);
    cycles(1);
    do_reset();
    load(2, 16'h0100);
    load(0, 16'h0200);
    drain();
    chk("rst_mid_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("rst_mid_g0", 32'(grant_log[0]), 32'd0);
      chk("rst_mid_g1", 32'(grant_log[1]), 32'd2);
    end
    chk("rst_mid_pkt_cnt", 32'(pkt_cnt), exp_cnt(2));

    // Mixed burst on all devices.
    do_reset();
    for (int i = 0; i < 12; i++)
      load(i % N, {8'($urandom_range(0, 5)), 8'($urandom_range(0, 255))});
    load(3, 16'hFFA5);
    drain();
    chk("mix_pkt_cnt", 32'(pkt_cnt), exp_cnt(m_pkt));
    chk("mix_drop_cnt", 32'(drop_cnt), exp_cnt(m_drop));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
